// File: rtl/clock_set_core.sv
// Settable HH:MM:SS clock core: synchronised keys, 1 Hz prescaler, RUN/SET_H/SET_M/SET_S FSM,
// 12/24-hour BCD display mapping and a half-second blink phase for the field being edited.
module clock_set_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter bit START_12H = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       fmt_toggle,
    output logic [3:0] h_tens,
    output logic [3:0] h_ones,
    output logic [3:0] m_tens,
    output logic [3:0] m_ones,
    output logic [3:0] s_tens,
    output logic [3:0] s_ones,
    output logic       pm,
    output logic [5:0] blank,
    output logic [1:0] mode
);
    localparam int            PW    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] B_MAX = PW'(CLK_HZ / 2 - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

    // Key path, bit 2=mode, 1=up, 0=down. Raw keys are active-low.
    logic [2:0] btn_s1, btn_s2, btn_prev, btn_armed, btn_ev;
    logic       warm;

    // A key only arms after a released level has been sampled post-reset, so a key
    // held through reset release cannot produce a press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1    <= '1;
            btn_s2    <= '1;
            btn_prev  <= '1;
            btn_armed <= '0;
            warm      <= 1'b0;
        end else begin
            btn_s1    <= {btn_mode, btn_up, btn_down};
            btn_s2    <= btn_s1;
            btn_prev  <= btn_s2;
            warm      <= 1'b1;
            btn_armed <= btn_armed | ({3{warm}} & btn_s1);
        end
    end

    assign btn_ev = btn_prev & ~btn_s2 & btn_armed;

    state_t        state;
    logic [PW-1:0] presc;
    logic [4:0]    hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic          tick, mode_ev, up_ev, dn_ev;

    assign mode_ev = btn_ev[2];
    assign up_ev   = btn_ev[1];
    assign dn_ev   = btn_ev[0];
    assign tick    = (state == RUN) && (presc == P_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            presc <= '0;
            hour  <= '0;
            min   <= '0;
            sec   <= '0;
        end else if (mode_ev) begin
            presc <= '0;
            case (state)
                RUN:     state <= SET_H;
                SET_H:   state <= SET_M;
                SET_M:   state <= SET_S;
                default: state <= RUN;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                presc <= '0;
                if (sec == 6'd59) begin
                    sec <= '0;
                    if (min == 6'd59) begin
                        min  <= '0;
                        hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            presc <= '0;
            // Simultaneous up and down cancel; fields wrap without carry or borrow.
            if (up_ev && !dn_ev) begin
                case (state)
                    SET_H:   hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    SET_M:   min  <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                    default: sec  <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                endcase
            end else if (dn_ev && !up_ev) begin
                case (state)
                    SET_H:   hour <= (hour == 5'd0) ? 5'd23 : hour - 5'd1;
                    SET_M:   min  <= (min == 6'd0) ? 6'd59 : min - 6'd1;
                    default: sec  <= (sec == 6'd0) ? 6'd59 : sec - 6'd1;
                endcase
            end
        end
    end

    logic          fmt12, phase;
    logic [PW-1:0] bcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt12 <= START_12H;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            if (fmt_toggle) fmt12 <= ~fmt12;
            if (bcnt == B_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + PW'(1);
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = '0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    logic [4:0] hour_disp;

    always_comb begin
        hour_disp = hour;
        if (fmt12) begin
            if (hour == 5'd0)       hour_disp = 5'd12;
            else if (hour > 5'd12)  hour_disp = hour - 5'd12;
        end
    end

    assign {h_tens, h_ones} = to_bcd({1'b0, hour_disp});
    assign {m_tens, m_ones} = to_bcd(min);
    assign {s_tens, s_ones} = to_bcd(sec);
    assign pm   = fmt12 && (hour >= 5'd12);
    assign mode = state;

    always_comb begin
        blank = '0;
        if (phase) begin
            case (state)
                SET_H:   blank = 6'b110000;
                SET_M:   blank = 6'b001100;
                SET_S:   blank = 6'b000011;
                default: blank = 6'b000000;
            endcase
        end
    end
endmodule

// File: doc/clock_set_core.md
CLOCK_SET_CORE -- requirements
Module: clock_set_core

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clk cycles per second; SHALL be even and >= 2.
REQ-002 Parameter START_12H, default 0, reset value of the 12/24-hour format bit.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 btn_mode  input  1  raw active-low mode key; debounced upstream, asynchronous to clk.
REQ-006 btn_up  input  1  raw active-low increment key; same rules as btn_mode.
REQ-007 btn_down  input  1  raw active-low decrement key; same rules as btn_mode.
REQ-008 fmt_toggle  input  1  synchronous single-cycle pulse; inverts the 12/24-hour format bit.
REQ-009 h_tens, h_ones, m_tens, m_ones, s_tens, s_ones  output  4 each  BCD display digits.
REQ-010 pm  output  1  1 when the 12-hour format is active and hour >= 12; otherwise 0.
REQ-011 blank  output  6  per-digit blank request, bit5=h_tens ... bit0=s_ones.
REQ-012 mode  output  2  FSM state: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer then a falling-edge detector, giving one press event per press.
REQ-014 A press SHALL change the time registers or state on the 3rd rising clk edge after the raw level falls; a held key SHALL give no further events.
REQ-015 Internal time SHALL be hour 0-23, min 0-59, sec 0-59 in binary; all outputs SHALL be combinational from registers.
REQ-016 Prescaler SHALL count 0..CLK_HZ-1 and wrap; tick SHALL assert for the one cycle in which count = CLK_HZ-1.
REQ-017 In RUN each tick SHALL advance sec; 59 -> 0 carries to min; min 59 -> 0 carries to hour; 23:59:59 -> 00:00:00.
REQ-018 Mode event transitions SHALL be RUN->SET_H->SET_M->SET_S->RUN.
REQ-019 In the SET states, time SHALL NOT advance, and the prescaler SHALL hold at 0.
REQ-020 On SET_S->RUN the prescaler SHALL restart from 0, so the first tick comes CLK_HZ cycles later.
REQ-021 In the SET states, an up event SHALL increment the selected field, wrapping hour 23->0 and min/sec 59->0.
REQ-022 In the SET states, a down event SHALL decrement the selected field, wrapping hour 0->23 and min/sec 0->59, with no carry or borrow into other fields.
REQ-023 Up and down events in the same cycle SHALL cancel (no change).
REQ-024 Up and down events in RUN SHALL be ignored.
REQ-025 A mode event in the same cycle as an up or down event SHALL take precedence; the up/down event is discarded.
REQ-026 A mode event in the same cycle as a tick in RUN SHALL take precedence; the tick is discarded.
REQ-027 In 24-hour format, h_tens/h_ones SHALL show hour in BCD.
REQ-028 In 12-hour format the hour display SHALL map 0->12, 1-12->same, 13-23->hour-12, and SHALL show h_tens=0 for 1-9.
REQ-029 The BCD split SHALL be combinational from the binary fields; values 0-59 only.
REQ-030 Blink phase SHALL be a free-running half-second divider of CLK_HZ/2 cycles that toggles in every state.
REQ-031 When the blink phase is 1, the two blank bits of the field selected by the current SET state SHALL be 1; all other blank bits SHALL be 0.
REQ-032 fmt_toggle SHALL alter only the display mapping and pm, never the time registers.

Reset
REQ-033 While rst=1: time=00:00:00, mode=RUN, prescaler=0, blink phase=0, sync/edge flops=1 (released), format bit=START_12H.
REQ-034 After reset with START_12H=0, the outputs SHALL be all digits 0, pm=0, blank=0.
REQ-035 After reset with START_12H=1, the outputs SHALL be h_tens=1, h_ones=2, all other digits 0, pm=0, blank=0.
REQ-036 Reset asserted mid-press or mid-SET SHALL abort it; a key still held at release SHALL NOT generate an event.

Verification (CLK_HZ=4)
REQ-037 Reset, run 240 cycles -> time 00:01:00; first sec increment at cycle 4.
REQ-038 Force 23:59:59 via SET, return to RUN, wait 4 cycles -> 00:00:00, no stray carry.
REQ-039 Mode press x1 then down x1 from 00 -> hour 23; with 12h format shows 11, pm=1; h_tens/h_ones blank bits pulse at the blink rate.
REQ-040 Up and down pressed in the same cycle in SET_M -> minute unchanged.
REQ-041 Mode press coinciding with a tick in RUN -> mode=SET_H, sec unchanged.
REQ-042 rst pulse while btn_up is held in SET_S -> 00:00:00, RUN, no increment after release of rst.
